// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_pkg
// Purpose  : Shared constants and helpers for the MCS-4 shift-register chain.
//            I4003_WIDTH_DEFAULT - bits in one i4003-equivalent stage
//            DIR_MSB / DIR_LSB   - encodings of the dir input
//            clog2()             - ceiling log2, used to size counters
// Revision : 1.0 - initial release
// ============================================================================
package mcs4_pkg;

    localparam int I4003_WIDTH_DEFAULT = 10;

    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

    // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
    // clog2(1) returns 0; callers guard against a zero-width result.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : mcs4_pkg
`default_nettype wire

// File: rtl/i4003_stage.sv
`default_nettype none
// ============================================================================
// Module   : i4003_stage
// Purpose  : One WIDTH-bit bidirectional shift stage (an i4003 equivalent).
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset, clears q
//            clear    - synchronous clear, clears q
//            shift_en - shift this cycle
//            dir      - DIR_MSB: data moves toward q[WIDTH-1], enters right_in
//                       DIR_LSB: data moves toward q[0], enters left_in
//            left_in  - bit entering at the MSB end (from the next-higher stage)
//            right_in - bit entering at the LSB end (from the next-lower stage)
//            q        - stage contents
// Revision : 1.0 - initial release
// ============================================================================
module i4003_stage
    import mcs4_pkg::*;
#(
    parameter int WIDTH = I4003_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             left_in,
    input  logic             right_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clear) begin
            r_q <= '0;
        end else if (shift_en) begin
            if (dir == DIR_LSB) begin
                r_q <= {left_in, r_q[WIDTH-1:1]};
            end else begin
                r_q <= {r_q[WIDTH-2:0], right_in};
            end
        end
    end

    assign q = r_q;

endmodule : i4003_stage
`default_nettype wire

// File: rtl/i4003_chain.sv
`default_nettype none
// ============================================================================
// Module   : i4003_chain
// Purpose  : STAGES chained i4003 stages forming one TOTAL = WIDTH*STAGES bit
//            shift register, clocked by rising edges of the cp strobe as
//            seen in the sysclk domain. Counts shifts and pulses frame_done
//            once per TOTAL shifts.
// Ports    : sysclk       - system clock, all logic on its rising edge
//            poc_pad      - synchronous active-high reset
//            cp           - shift strobe, slower than sysclk
//            serial_in    - serial data input
//            enable       - parallel output enable (does not gate shifting)
//            dir          - 0: shift toward MSB, 1: shift toward LSB
//            clear        - synchronous clear of register and counter
//            parallel_out - register image, forced to 0 when enable is low
//            serial_out   - bit about to leave the chain in the current dir
//            frame_done   - one-cycle pulse after every TOTAL shifts
// Config   : I4003_CHAIN_LATCH_EN - when defined, parallel_out shows a hold
//            register loaded only on frame completion, so partial frames
//            are never visible.
// Revision : 1.0 - initial release
// ============================================================================
module i4003_chain
    import mcs4_pkg::*;
#(
    parameter int WIDTH  = I4003_WIDTH_DEFAULT,
    parameter int STAGES = 1
) (
    input  logic                      sysclk,
    input  logic                      poc_pad,
    input  logic                      cp,
    input  logic                      serial_in,
    input  logic                      enable,
    input  logic                      dir,
    input  logic                      clear,
    output logic [WIDTH*STAGES-1:0]   parallel_out,
    output logic                      serial_out,
    output logic                      frame_done
);

    localparam int TOTAL   = WIDTH * STAGES;
    localparam int c_CNT_W = (clog2(TOTAL) < 1) ? 1 : clog2(TOTAL);

    logic               r_cp_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_frame_done;
    logic               w_shift;
    logic               w_frame_end;
    logic [TOTAL-1:0]   w_sr;
    logic [STAGES-1:0]  w_left_in;
    logic [STAGES-1:0]  w_right_in;

    // r_cp_d resets high so a cp held high across reset release is not
    // mistaken for a rising edge.
    assign w_shift     = cp & ~r_cp_d;
    assign w_frame_end = w_shift & (r_cnt == c_CNT_W'(TOTAL - 1));

    // Stage k occupies w_sr[k*WIDTH +: WIDTH]. serial_in enters stage 0 when
    // shifting toward the MSB and the top stage when shifting toward the LSB.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_right_serial
                assign w_right_in[k] = serial_in;
            end else begin : g_right_chain
                assign w_right_in[k] = w_sr[k*WIDTH-1];
            end

            if (k == STAGES - 1) begin : g_left_serial
                assign w_left_in[k] = serial_in;
            end else begin : g_left_chain
                assign w_left_in[k] = w_sr[(k+1)*WIDTH];
            end

            i4003_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (sysclk),
                .rst      (poc_pad),
                .clear    (clear),
                .shift_en (w_shift),
                .dir      (dir),
                .left_in  (w_left_in[k]),
                .right_in (w_right_in[k]),
                .q        (w_sr[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge sysclk) begin
        if (poc_pad) begin
            r_cp_d       <= 1'b1;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_cp_d <= cp;
            if (clear) begin
                r_cnt        <= '0;
                r_frame_done <= 1'b0;
            end else begin
                r_frame_done <= w_frame_end;
                if (w_frame_end) begin
                    r_cnt <= '0;
                end else if (w_shift) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign frame_done = r_frame_done;
    assign serial_out = (dir == DIR_LSB) ? w_sr[0] : w_sr[TOTAL-1];

`ifdef I4003_CHAIN_LATCH_EN
    logic [TOTAL-1:0] r_hold;
    logic [TOTAL-1:0] w_sr_next;

    // Post-shift image, so the hold register matches the chain contents on
    // the cycle frame_done is high.
    assign w_sr_next = (dir == DIR_LSB) ? {serial_in, w_sr[TOTAL-1:1]}
                                        : {w_sr[TOTAL-2:0], serial_in};

    always_ff @(posedge sysclk) begin
        if (poc_pad) begin
            r_hold <= '0;
        end else if (clear) begin
            r_hold <= '0;
        end else if (w_frame_end) begin
            r_hold <= w_sr_next;
        end
    end

    assign parallel_out = enable ? r_hold : '0;
`else
    assign parallel_out = enable ? w_sr : '0;
`endif

endmodule : i4003_chain
`default_nettype wire

// File: tb/tb_i4003_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_i4003_chain
// Purpose  : Self-checking bench for i4003_chain. Two instances (10x1 and
//            4x3) share one stimulus stream; a word-level reference model
//            per instance predicts every output each cycle, and directed
//            phases pin literal values from hand-worked sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i4003_chain;

    localparam int TA = 10;
    localparam int TB = 12;

    logic          sysclk;
    logic          poc_pad;
    logic          cp;
    logic          serial_in;
    logic          enable;
    logic          dir;
    logic          clear;
    logic [TA-1:0] par_a;
    logic [TB-1:0] par_b;
    logic          ser_a, ser_b;
    logic          fd_a, fd_b;

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt_a = 0;
    int fd_cnt_b = 0;
    bit run_chk  = 0;

    typedef struct packed {
        logic [255:0] sr;
        logic [255:0] hold;
        logic [31:0]  cnt;
        logic         cpd;
        logic         fd;
    } model_t;

    model_t m_a, m_b;

    i4003_chain #(.WIDTH(10), .STAGES(1)) u_dut_a (
        .sysclk       (sysclk),
        .poc_pad      (poc_pad),
        .cp           (cp),
        .serial_in    (serial_in),
        .enable       (enable),
        .dir          (dir),
        .clear        (clear),
        .parallel_out (par_a),
        .serial_out   (ser_a),
        .frame_done   (fd_a)
    );

    i4003_chain #(.WIDTH(4), .STAGES(3)) u_dut_b (
        .sysclk       (sysclk),
        .poc_pad      (poc_pad),
        .cp           (cp),
        .serial_in    (serial_in),
        .enable       (enable),
        .dir          (dir),
        .clear        (clear),
        .parallel_out (par_b),
        .serial_out   (ser_b),
        .frame_done   (fd_b)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register as a plain integer: toward MSB is multiply-by-two plus the new
    // bit, toward LSB is divide-by-two with the new bit weighted 2^(total-1).
    task automatic model_step(inout model_t m, input int total);
        logic [255:0] mask;
        bit           ev;
        mask = (256'd1 << total) - 256'd1;
        if (poc_pad) begin
            m     = '0;
            m.cpd = 1'b1;
        end else begin
            ev    = cp && !m.cpd;
            m.cpd = cp;
            m.fd  = 1'b0;
            if (clear) begin
                m.sr   = '0;
                m.hold = '0;
                m.cnt  = 0;
            end else if (ev) begin
                if (dir == 1'b0)
                    m.sr = ((m.sr * 2) + 256'(serial_in)) & mask;
                else
                    m.sr = (m.sr / 2) + (256'(serial_in) << (total - 1));
                m.cnt = m.cnt + 1;
                if (m.cnt == total) begin
                    m.cnt  = 0;
                    m.fd   = 1'b1;
                    m.hold = m.sr;
                end
            end
        end
    endtask

    function automatic logic [255:0] exp_par(input model_t m);
        if (!enable) return '0;
`ifdef I4003_CHAIN_LATCH_EN
        return m.hold;
`else
        return m.sr;
`endif
    endfunction

    always @(posedge sysclk) begin
        model_step(m_a, TA);
        model_step(m_b, TB);
    end

    // Single compare process: every cycle, #1 after the active edge.
    always @(posedge sysclk) begin
        #1;
        if (fd_a === 1'b1) fd_cnt_a = fd_cnt_a + 1;
        if (fd_b === 1'b1) fd_cnt_b = fd_cnt_b + 1;
        if (run_chk) begin
            chk("par_a", 256'(par_a), exp_par(m_a));
            chk("ser_a", 256'(ser_a), 256'(dir ? m_a.sr[0] : m_a.sr[TA-1]));
            chk("fd_a",  256'(fd_a),  256'(m_a.fd));
            chk("par_b", 256'(par_b), exp_par(m_b));
            chk("ser_b", 256'(ser_b), 256'(dir ? m_b.sr[0] : m_b.sr[TB-1]));
            chk("fd_b",  256'(fd_b),  256'(m_b.fd));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic do_shift(input logic b);
        @(negedge sysclk);
        serial_in = b;
        cp        = 1'b1;
        @(negedge sysclk);
        cp        = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic do_clear();
        @(negedge sysclk);
        clear = 1'b1;
        @(negedge sysclk);
        clear = 1'b0;
    endtask

    logic [9:0] pat;
    int         fd_snap;

    initial begin
        pat       = 10'b1011001110;
        poc_pad   = 1'b1;
        cp        = 1'b1;
        serial_in = 1'b0;
        enable    = 1'b1;
        dir       = 1'b0;
        clear     = 1'b0;
        cycles(3);
        poc_pad = 1'b0;
        run_chk = 1;
        cycles(5);
        chk("reset_par_a", 256'(par_a), 256'd0);
        chk("reset_ser_a", 256'(ser_a), 256'd0);
        chk("reset_fd_a",  256'(fd_a),  256'd0);
        chk("reset_fd_cnt", 256'(fd_cnt_a + fd_cnt_b), 256'd0);
        @(negedge sysclk);
        cp = 1'b0;

        // Pattern 1,0,1,1,0,0,1,1,1,0 toward MSB, first bit first.
        for (int i = 9; i >= 0; i--) do_shift(pat[i]);
        chk("msb_pattern", 256'(par_a), 256'(10'b1011001110));
        chk("msb_model",   m_a.sr,      256'(10'b1011001110));
        chk("msb_fd_once", 256'(fd_cnt_a), 256'd1);

        // Same pattern toward LSB.
        do_clear();
        dir = 1'b1;
        for (int i = 9; i >= 0; i--) do_shift(pat[i]);
        chk("lsb_pattern", 256'(par_a), 256'(10'b0111001101));
        chk("lsb_ser",     256'(ser_a), 256'd1);
        @(negedge sysclk);
        enable = 1'b0;
        @(negedge sysclk);
        chk("enable_off", 256'(par_a), 256'd0);
        enable = 1'b1;
        @(negedge sysclk);
        chk("enable_on",  256'(par_a), 256'(10'b0111001101));

        // Single 1 through the 12-bit chain.
        do_clear();
        dir      = 1'b0;
        fd_snap  = fd_cnt_b;
        do_shift(1'b1);
        for (int i = 0; i < 11; i++) do_shift(1'b0);
        chk("chain_ser_12", 256'(ser_b), 256'd1);
        chk("chain_fd_12",  256'(fd_cnt_b - fd_snap), 256'd1);
        for (int i = 0; i < 12; i++) do_shift(1'b0);
        chk("chain_fd_24",  256'(fd_cnt_b - fd_snap), 256'd2);
        chk("chain_ser_24", 256'(ser_b), 256'd0);

        // Clear coincident with a cp rise at cnt=5.
        do_clear();
        for (int i = 0; i < 5; i++) do_shift(1'b1);
        @(negedge sysclk);
        clear     = 1'b1;
        cp        = 1'b1;
        serial_in = 1'b1;
        @(negedge sysclk);
        clear = 1'b0;
        cp    = 1'b0;
        @(negedge sysclk);
        chk("clear_wins", 256'(par_a), 256'd0);
        fd_snap = fd_cnt_a;
        for (int i = 0; i < 9; i++) do_shift(1'b1);
        chk("clear_no_fd_9", 256'(fd_cnt_a - fd_snap), 256'd0);
        do_shift(1'b1);
        chk("clear_fd_10",   256'(fd_cnt_a - fd_snap), 256'd1);

        // Reset mid-frame at cnt=7 discards the partial frame.
        for (int i = 0; i < 7; i++) do_shift(1'b1);
        @(negedge sysclk);
        poc_pad = 1'b1;
        @(negedge sysclk);
        poc_pad = 1'b0;
        fd_snap = fd_cnt_a;
        for (int i = 0; i < 3; i++) do_shift(1'b1);
        chk("reset_no_fd", 256'(fd_cnt_a - fd_snap), 256'd0);
        chk("reset_par",   256'(par_a), 256'(10'b0000000111));

        // Randomised traffic, including rare clear and reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge sysclk);
            if ($urandom_range(0, 1) == 0) cp = ~cp;
            serial_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) dir    = ~dir;
            if ($urandom_range(0, 7) == 0)  enable = ~enable;
            clear   = ($urandom_range(0, 99) == 0);
            poc_pad = ($urandom_range(0, 299) == 0);
        end
        @(negedge sysclk);
        clear   = 1'b0;
        poc_pad = 1'b0;
        cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_i4003_chain
`default_nettype wire

// File: doc/i4003_chain.md
Name: i4003_chain

Overview:
Parametrised successor to the single i4003 shift register used in the MCS-4 system top.
- Chains STAGES shift-register stages of WIDTH bits each into one TOTAL = WIDTH*STAGES bit register.
- Shifts on rising edges of the cp strobe, which is sampled in the sysclk domain.
- Supports shift-direction selection, a synchronous clear, frame counting and a gated parallel output.
- Sits beside i4001/i4002 on the MCS-4 top and is fed from the 4004 data/IO lines.

Parameters:
WIDTH, 10, bits per stage (one i4003 equivalent), range 2..32
STAGES, 1, number of chained stages, range 1..8
TOTAL, WIDTH*STAGES, derived local constant; not overridable

Ports:
sysclk  input  1  system clock; all logic is on its rising edge
poc_pad  input  1  reset; synchronous, active-high
cp  input  1  shift strobe (clk2_pad on the top); asynchronous to sysclk phase, slower than sysclk
serial_in  input  1  serial data input
enable  input  1  parallel output enable
dir  input  1  0 = shift toward MSB, 1 = shift toward LSB
clear  input  1  synchronous clear of register and counter
parallel_out  output  TOTAL  register image, gated by enable
serial_out  output  1  bit leaving the chain
frame_done  output  1  one-sysclk pulse after every TOTAL shifts

Behaviour:
- Edge detect: cp_d <= cp every sysclk. A shift event is cp & ~cp_d.
- poc_pad sets cp_d to 1, so a cp held high through reset release causes no shift.
- Shift, dir=0: sr <= {sr[TOTAL-2:0], serial_in}. serial_out = sr[TOTAL-1].
- Shift, dir=1: sr <= {serial_in, sr[TOTAL-1:1]}. serial_out = sr[0].
- serial_out is a combinational select of sr bits by dir. It changes on a dir change without a shift.
- serial_in is sampled on the same sysclk edge that samples the cp rise. sr is updated at that edge; latency is 1 sysclk from the cp rise being seen.
- Counter cnt, width clog2(TOTAL), range 0..TOTAL-1, increments on each shift event.
- When cnt == TOTAL-1 and a shift occurs, cnt wraps to 0 and frame_done is registered high for exactly the next cycle.
- Back-to-back frames: frame_done pulses once per frame, never held.
- parallel_out = enable ? sr : 0, combinational from the register. enable does not affect shifting.
- clear (synchronous): sr <= 0, cnt <= 0, frame_done <= 0. cp_d is still updated.
- clear and a shift event in the same cycle: clear wins and the shift is discarded.
- dir change mid-frame: cnt is not reset; the new direction applies from the next shift.
- Reset values: sr=0, cnt=0, frame_done=0, cp_d=1. Outputs: parallel_out=0, serial_out=0, frame_done=0.
- Reset mid-frame discards all state; the partial frame produces no frame_done.
- poc_pad has priority over clear, which has priority over shift.

Optional Feature:
Macro I4003_CHAIN_LATCH_EN.
- Defined:
  - Adds a TOTAL-bit hold register, reset and clear to 0.
  - On the shift that completes a frame, hold loads the post-shift sr value.
  - parallel_out = enable ? hold : 0, so it changes in the same cycle frame_done rises.
  - Partial frames are never visible.
- Undefined: no hold register; parallel_out tracks sr live as above.

Decomposition:
- Package mcs4_pkg:
  - I4003_WIDTH_DEFAULT=10
  - DIR_MSB=1'b0, DIR_LSB=1'b1
  - function clog2 for the counter width
- Sub-module i4003_stage: one WIDTH-bit bidirectional stage with shift_en, dir, left_in, right_in, q.
- i4003_chain generates STAGES instances with neighbour wiring, plus the edge detector, counter and optional hold in the top.

Test Plan:
- Reset with cp=1, then hold cp=1 for 5 cycles -> no shift. Check sr=0, serial_out=0, frame_done=0, parallel_out=0.
- WIDTH=10, STAGES=1, dir=0, enable=1: shift serial_in 1,0,1,1,0,0,1,1,1,0 (first bit first) -> parallel_out=10'b1011001110 after the tenth cp rise. frame_done is high exactly 1 cycle after that shift.
- Same pattern with dir=1 -> parallel_out=10'b0111001101. serial_out = sr[0]. Toggle enable=0 -> parallel_out=0 while sr is retained.
- STAGES=3, WIDTH=4: 12 shifts of a single 1 followed by 0s, dir=0 -> the 1 appears at serial_out after 12 cp rises. frame_done pulses once at 12 and again at 24.
- Assert clear coincident with a cp rise at cnt=5 -> sr=0, cnt=0, no shift. A frame_done then needs 10 further shifts. Apply poc_pad at cnt=7 -> no frame_done.
- With I4003_CHAIN_LATCH_EN: parallel_out stays 0 through shifts 1..9 and shows the full pattern in the frame_done cycle. Without the macro, parallel_out updates on every shift.
